// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I datapath: per-state mux selects, memory handshake, trap handling.
// Optional PERF_CNT_EN adds cycleCnt/instRet performance counters.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWrite,
  output logic        adrSrc,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        regWrite,
  output logic [1:0]  resultSrc,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  aluOp,
  output logic [1:0]  immSrc,
  output logic [3:0]  state,
  output logic        trap,
`ifdef PERF_CNT_EN
  output logic [31:0] cycleCnt,
  output logic [31:0] instRet,
`endif
  output logic [1:0]  trapCause
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC + 4 on memReady
  // DECODE   | ALUOut <= OldPC + imm (branch/jump target), dispatch on opcode
  // MEMADR   | ALUOut <= rs1 + imm
  // MEMREAD  | load data from ALUOut address
  // MEMWB    | rd <= Data
  // MEMWRITE | store rs2 to ALUOut address
  // EXECR    | ALUOut <= rs1 op rs2
  // EXECI    | ALUOut <= rs1 op imm
  // ALUWB    | rd <= ALUOut
  // BEQ      | compare rs1/rs2, PC <= ALUOut when zero
  // JALR     | ALUOut <= rs1 + imm
  // JUMP     | PC <= ALUOut, ALUOut <= OldPC + 4 for the link write
  // TRAP     | sticky fault, left only by reset
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JUMP     = 4'd10,
    S_JALR     = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t         cur_state, nxt_state;
  logic [1:0]     cause_q, cause_d;
  logic [WCW-1:0] wait_cnt;
  logic           mem_wait_st, timeout;

  assign mem_wait_st = (cur_state == S_FETCH) || (cur_state == S_MEMREAD) ||
                       (cur_state == S_MEMWRITE);
  // the timeout fires on the cycle that would be the MEM_TIMEOUT-th wait; memReady wins
  assign timeout = (MEM_TIMEOUT != 0) && mem_wait_st && !memReady && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
      cause_q   <= 2'b00;
      wait_cnt  <= '0;
    end else begin
      cur_state <= nxt_state;
      cause_q   <= cause_d;
      if (nxt_state != cur_state)
        wait_cnt <= '0;
      else if (mem_wait_st && !memReady && (wait_cnt != '1))
        wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  always_comb begin
    nxt_state = cur_state;
    cause_d   = cause_q;
    case (cur_state)
      S_FETCH: begin
        if (memReady) nxt_state = S_DECODE;
        else if (timeout) begin
          nxt_state = S_TRAP;
          cause_d   = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_R:         nxt_state = S_EXECR;
          OP_I:         nxt_state = S_EXECI;
          OP_BEQ:       nxt_state = S_BEQ;
          OP_JAL:       nxt_state = S_JUMP;
          OP_JALR:      nxt_state = S_JALR;
          default: begin
            nxt_state = S_TRAP;
            cause_d   = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: nxt_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (memReady) nxt_state = S_MEMWB;
        else if (timeout) begin
          nxt_state = S_TRAP;
          cause_d   = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB: nxt_state = S_FETCH;
      S_MEMWRITE: begin
        if (memReady) nxt_state = S_FETCH;
        else if (timeout) begin
          nxt_state = S_TRAP;
          cause_d   = CAUSE_TIMEOUT;
        end
      end
      S_EXECR: nxt_state = S_ALUWB;
      S_EXECI: nxt_state = S_ALUWB;
      S_ALUWB: nxt_state = S_FETCH;
      S_BEQ:   nxt_state = S_FETCH;
      S_JALR:  nxt_state = S_JUMP;
      S_JUMP:  nxt_state = S_ALUWB;
      S_TRAP:  nxt_state = S_TRAP;
      default: nxt_state = S_TRAP;
    endcase
  end

  // rst_n gates every output so an access in flight is dropped the moment reset asserts
  always_comb begin
    memReq    = 1'b0;
    memWrite  = 1'b0;
    adrSrc    = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    immSrc    = 2'b00;
    state     = 4'd0;
    trap      = 1'b0;
    trapCause = 2'b00;
    if (rst_n) begin
      state     = cur_state;
      trapCause = cause_q;
      case (cur_state)
        S_FETCH: begin
          memReq    = 1'b1;
          aluSrcB   = 2'b10;
          resultSrc = 2'b10;
          irWrite   = memReady;
          pcWrite   = memReady;
        end
        S_DECODE: begin
          aluSrcA = 2'b01;
          aluSrcB = 2'b01;
          case (opcode)
            OP_SW:   immSrc = 2'b01;
            OP_BEQ:  immSrc = 2'b10;
            OP_JAL:  immSrc = 2'b11;
            default: immSrc = 2'b00;
          endcase
        end
        S_MEMADR: begin
          aluSrcA = 2'b10;
          aluSrcB = 2'b01;
          immSrc  = (opcode == OP_SW) ? 2'b01 : 2'b00;
        end
        S_MEMREAD: begin
          memReq = 1'b1;
          adrSrc = 1'b1;
        end
        S_MEMWB: begin
          resultSrc = 2'b01;
          regWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          memReq   = 1'b1;
          memWrite = 1'b1;
          adrSrc   = 1'b1;
        end
        S_EXECR: begin
          aluSrcA = 2'b10;
          aluOp   = 2'b10;
        end
        S_EXECI: begin
          aluSrcA = 2'b10;
          aluSrcB = 2'b01;
          aluOp   = 2'b11;
        end
        S_ALUWB: regWrite = 1'b1;
        S_BEQ: begin
          aluSrcA = 2'b10;
          aluOp   = 2'b01;
          pcWrite = zero;
        end
        S_JALR: begin
          aluSrcA = 2'b10;
          aluSrcB = 2'b01;
        end
        S_JUMP: begin
          pcWrite = 1'b1;
          aluSrcA = 2'b01;
          aluSrcB = 2'b10;
        end
        S_TRAP: trap = 1'b1;
        default: trap = 1'b1;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic retire;
  assign retire = (cur_state == S_MEMWB) || (cur_state == S_ALUWB) ||
                  (cur_state == S_BEQ) || ((cur_state == S_MEMWRITE) && memReady);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt <= 32'd0;
      instRet  <= 32'd0;
    end else begin
      if (cur_state != S_TRAP) cycleCnt <= cycleCnt + 32'd1;
      if (retire)              instRet  <= instRet + 32'd1;
    end
  end
`endif

endmodule
